// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual select or round-robin scan over an
// enable mask, presenting one sample per cycle on a valid/ready output.
module mux_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int AW       = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [AW-1:0]             a,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       en_mask,
    output logic [WIDTH-1:0]          q,
    output logic [AW-1:0]             q_sel,
    output logic                      q_valid,
    input  logic                      q_ready
);

    logic [WIDTH-1:0]    q_r;
    logic [AW-1:0]       q_sel_r;
    logic                q_valid_r;
    logic [AW-1:0]       ptr_r;

    logic                load_s;
    logic                man_ok_s;
    logic                hi_found_s;
    logic                any_found_s;
    logic [AW-1:0]       hi_idx_s;
    logic [AW-1:0]       lo_idx_s;
    logic [AW-1:0]       scan_idx_s;
    logic [AW-1:0]       ptr_next_s;
    logic [CHANNELS-1:0] onehot_s;
    logic [WIDTH-1:0]    sel_data_s;
    logic [AW-1:0]       nxt_sel_s;
    logic                nxt_valid_s;

    assign load_s   = !q_valid_r || q_ready;
    assign man_ok_s = int'(a) < CHANNELS;

    // Rotating-priority search: lowest enabled index at or above ptr, else lowest enabled overall.
    always_comb begin
        hi_found_s  = 1'b0;
        any_found_s = 1'b0;
        hi_idx_s    = '0;
        lo_idx_s    = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (en_mask[k]) begin
                any_found_s = 1'b1;
                lo_idx_s    = AW'(k);
                if (k >= int'(ptr_r)) begin
                    hi_found_s = 1'b1;
                    hi_idx_s   = AW'(k);
                end else begin
                    hi_found_s = hi_found_s;
                end
            end else begin
                any_found_s = any_found_s;
            end
        end
        if (hi_found_s) begin
            scan_idx_s = hi_idx_s;
        end else begin
            scan_idx_s = lo_idx_s;
        end
        if (scan_idx_s == AW'(CHANNELS - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = scan_idx_s + AW'(1);
        end
    end

    // One-hot decode of the chosen channel feeding an AND-OR data selector.
    always_comb begin
        onehot_s   = '0;
        sel_data_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (mode) begin
                onehot_s[k] = any_found_s && (scan_idx_s == AW'(k));
            end else begin
                onehot_s[k] = man_ok_s && (a == AW'(k));
            end
            sel_data_s = sel_data_s | (d[k*WIDTH +: WIDTH] & {WIDTH{onehot_s[k]}});
        end
        if (mode) begin
            nxt_sel_s   = any_found_s ? scan_idx_s : '0;
            nxt_valid_s = any_found_s;
        end else begin
            nxt_sel_s   = a;
            nxt_valid_s = man_ok_s;
        end
    end

    // Output register and scan pointer; everything holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r       <= '0;
            q_sel_r   <= '0;
            q_valid_r <= 1'b0;
            ptr_r     <= '0;
        end else if (load_s) begin
            q_r       <= sel_data_s;
            q_sel_r   <= nxt_sel_s;
            q_valid_r <= nxt_valid_s;
            if (mode && any_found_s) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end else begin
            q_r       <= q_r;
            q_sel_r   <= q_sel_r;
            q_valid_r <= q_valid_r;
            ptr_r     <= ptr_r;
        end
    end

    assign q       = q_r;
    assign q_sel   = q_sel_r;
    assign q_valid = q_valid_r;

endmodule
